key_command_decoder: RTL

KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

---
 rtl/key_command_decoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/key_command_decoder.sv
// PS/2 set-2 scan-code decoder: turns make/break sequences into single-cycle game commands
// and held-key levels. Define KEY_AUTOREPEAT_EN to add auto-repeat of left/right/down.
module key_command_decoder #(
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] codeIn,
    output logic       cmdLeft,
    output logic       cmdRight,
    output logic       cmdRotate,
    output logic       cmdDown,
    output logic       cmdDrop,
    output logic       cmdPause,
    output logic       heldLeft,
    output logic       heldRight,
    output logic       heldDown
);

    function automatic logic [23:0] sat24(input int v);
        if (v > 32'h00FF_FFFF) return 24'hFF_FFFF;
        return v[23:0];
    endfunction

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || PREFIX_TIMEOUT < 1) begin : g_bad_param
        $error("key_command_decoder: timing parameters must be at least 1");
    end

    localparam logic [23:0] TMO_LOAD = sat24(PREFIX_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    // cmd bit order: left, right, down, rotate, drop, pause; held uses the first three.
    state_t      state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [23:0] tmo_q, tmo_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [2:0]  held_q, held_d;
    logic        accept, dec_make, dec_brk, dec_ext;
    logic [5:0]  key_hit;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [23:0] DELAY_LOAD  = sat24(REPEAT_DELAY);
    localparam logic [23:0] PERIOD_LOAD = sat24(REPEAT_PERIOD);

    // rpt_tgt: 0 = none, otherwise held index + 1
    logic [1:0]  rpt_tgt_q, rpt_tgt_d;
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_tgt_q <= 2'd0;
            rpt_cnt_q <= 24'd0;
        end else begin
            rpt_tgt_q <= rpt_tgt_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            code_q  <= 8'h00;
            tmo_q   <= 24'd0;
            cmd_q   <= 6'd0;
            held_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tmo_q   <= tmo_d;
            cmd_q   <= cmd_d;
            held_q  <= held_d;
        end
    end

    assign accept = (codeIn != 8'h00) && (code_q == 8'h00);

    always_comb begin
        state_d  = state_q;
        code_d   = codeIn;
        tmo_d    = tmo_q;
        cmd_d    = 6'd0;
        held_d   = held_q;
        dec_make = 1'b0;
        dec_brk  = 1'b0;
        dec_ext  = 1'b0;

        if (accept) begin
            tmo_d = TMO_LOAD;
            case (state_q)
                S_IDLE: begin
                    if (codeIn == 8'hE0)      state_d = S_EXT;
                    else if (codeIn == 8'hF0) state_d = S_BRK;
                    else                      dec_make = 1'b1;
                end
                S_EXT: begin
                    if (codeIn == 8'hF0)      state_d = S_EXT_BRK;
                    else if (codeIn == 8'hE0) state_d = S_EXT;
                    else begin
                        dec_make = 1'b1;
                        dec_ext  = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (codeIn != 8'hF0) begin
                        dec_brk = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    dec_brk = 1'b1;
                    dec_ext = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Abandon a dangling prefix once the timeout down-counter reaches terminal count.
            if (tmo_q <= 24'd1) begin
                state_d = S_IDLE;
                tmo_d   = 24'd0;
            end else begin
                tmo_d = tmo_q - 24'd1;
            end
        end

        key_hit[0] = dec_ext  && (codeIn == 8'h6B);
        key_hit[1] = dec_ext  && (codeIn == 8'h74);
        key_hit[2] = dec_ext  && (codeIn == 8'h72);
        key_hit[3] = dec_ext  && (codeIn == 8'h75);
        key_hit[4] = !dec_ext && (codeIn == 8'h29);
        key_hit[5] = !dec_ext && (codeIn == 8'h4D);

        if (dec_make) begin
            for (int i = 0; i < 3; i++) begin
                if (key_hit[i] && !held_q[i]) begin
                    cmd_d[i]  = 1'b1;
                    held_d[i] = 1'b1;
                end
            end
            for (int i = 3; i < 6; i++) begin
                if (key_hit[i]) cmd_d[i] = 1'b1;
            end
        end
        if (dec_brk) begin
            for (int i = 0; i < 3; i++) begin
                if (key_hit[i]) held_d[i] = 1'b0;
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        rpt_tgt_d = rpt_tgt_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (rpt_tgt_q != 2'd0) begin
            if (rpt_cnt_q <= 24'd1) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = PERIOD_LOAD;
            end else begin
                rpt_cnt_d = rpt_cnt_q - 24'd1;
            end
        end
        // A fresh press retargets (or, for non-repeatable keys, stops) the repeat.
        if (cmd_d != 6'd0) begin
            rpt_fire  = 1'b0;
            rpt_cnt_d = DELAY_LOAD;
            if (cmd_d[0])      rpt_tgt_d = 2'd1;
            else if (cmd_d[1]) rpt_tgt_d = 2'd2;
            else if (cmd_d[2]) rpt_tgt_d = 2'd3;
            else               rpt_tgt_d = 2'd0;
        end else if (dec_brk && (rpt_tgt_q != 2'd0) && key_hit[{1'b0, rpt_tgt_q} - 3'd1]) begin
            rpt_fire  = 1'b0;
            rpt_tgt_d = 2'd0;
            rpt_cnt_d = DELAY_LOAD;
        end
        if (rpt_fire) cmd_d[{1'b0, rpt_tgt_q} - 3'd1] = 1'b1;
`endif
    end

    assign cmdLeft   = cmd_q[0];
    assign cmdRight  = cmd_q[1];
    assign cmdDown   = cmd_q[2];
    assign cmdRotate = cmd_q[3];
    assign cmdDrop   = cmd_q[4];
    assign cmdPause  = cmd_q[5];
    assign heldLeft  = held_q[0];
    assign heldRight = held_q[1];
    assign heldDown  = held_q[2];

endmodule
